// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1-class mapper: register indices,
// the control-register reset value and the PRG/mirroring mode encodings.
package mmc1_pkg;

  // Internal register addressed by CPU A[14:13] on the committing write.
  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_CHR0 = 2'd1,
    REG_CHR1 = 2'd2,
    REG_PRG  = 2'd3
  } reg_idx_e;

  // PRG mode 3 (fix last bank at $C000), 8 KB CHR, one-screen low.
  localparam logic [4:0] CTRL_RESET = 5'b01100;

  // Control[3:2] PRG banking modes.
  localparam logic [1:0] PRG_MODE_32K_A     = 2'b00;
  localparam logic [1:0] PRG_MODE_32K_B     = 2'b01;
  localparam logic [1:0] PRG_MODE_FIX_FIRST = 2'b10;
  localparam logic [1:0] PRG_MODE_FIX_LAST  = 2'b11;

  // Control[1:0] nametable mirroring modes.
  localparam logic [1:0] MIRROR_ONE_LOW  = 2'b00;
  localparam logic [1:0] MIRROR_ONE_HIGH = 2'b01;
  localparam logic [1:0] MIRROR_VERT     = 2'b10;
  localparam logic [1:0] MIRROR_HORZ     = 2'b11;

endpackage

// File: rtl/mmc1_serial_loader.sv
// Serial write front end: consecutive-write filter, shift register, bit
// counter, and the commit / shift-reset strobes towards the register file.
//
// Strobe interface: commit_o and shift_reset_o are combinational, mutually
// exclusive and valid only for the M2 falling edge at which the write is
// sampled. The register file has no back-pressure; it must consume
// commit_idx_o / commit_data_o on that same edge.
module mmc1_serial_loader
  import mmc1_pkg::*;
#(
  parameter int SHIFT_LEN     = 5,
  parameter bit CONSEC_FILTER = 1'b1,
  localparam int CNT_W        = $clog2(SHIFT_LEN)
) (
  input  logic                 cpu_m2_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic                 d0_i,
  input  logic                 d7_i,
  input  logic [1:0]           cpu_a_i,
  output logic                 commit_o,
  output reg_idx_e             commit_idx_o,
  output logic [SHIFT_LEN-1:0] commit_data_o,
  output logic                 shift_reset_o,
  output logic [CNT_W-1:0]     shift_cnt_o
);

  // Only load[SHIFT_LEN-1:1] ever reaches a commit (the oldest bit falls out
  // on the final shift), so the register keeps just those SHIFT_LEN-1 bits.
  logic [SHIFT_LEN-2:0] load_q, load_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_wr_q;
  logic                 accept;
  logic                 last_bit;

  // Classify the sampled write and compute the next shift state.
  always_comb begin
    accept        = wr_i & ~(CONSEC_FILTER & last_wr_q);
    last_bit      = (cnt_q == CNT_W'(SHIFT_LEN - 1));
    shift_reset_o = accept & d7_i;
    commit_o      = accept & ~d7_i & last_bit;
    commit_idx_o  = reg_idx_e'(cpu_a_i);
    commit_data_o = {d0_i, load_q};
    load_d        = load_q;
    cnt_d         = cnt_q;
    if (shift_reset_o || commit_o) begin
      load_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      load_d = {d0_i, load_q[SHIFT_LEN-2:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Shift state advances on the falling edge of M2; reset drops any partial load.
  always_ff @(negedge cpu_m2_i or posedge rst_i) begin
    if (rst_i) begin
      load_q    <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      load_q    <= load_d;
      cnt_q     <= cnt_d;
      last_wr_q <= wr_i;
    end
  end

  assign shift_cnt_o = cnt_q;

endmodule

// File: rtl/mmc1_param_mapper.sv
// MMC1-class cartridge mapper: register file fed by the serial loader plus
// combinational PRG/CHR bank, mirroring and chip-enable decode.
module mmc1_param_mapper
  import mmc1_pkg::*;
#(
  parameter int SHIFT_LEN     = 5,
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5,
  parameter bit WRAM_DIS_EN   = 1'b1,
  parameter bit CONSEC_FILTER = 1'b1,
  localparam int CNT_W        = $clog2(SHIFT_LEN)
) (
  input  logic                     CPU_M2,
  input  logic                     RESET,
  input  logic                     nCPU_ROMSEL,
  input  logic                     nCPU_RW,
  input  logic [1:0]               CPU_A,
  input  logic                     CPU_D0,
  input  logic                     CPU_D7,
  input  logic                     CPU_A_WR,
  input  logic [2:0]               PPU_A,
  output logic [PRG_BANK_BITS-1:0] PRG_A,
  output logic [CHR_BANK_BITS-1:0] CHR_A,
  output logic                     CIRAM_A10,
  output logic                     nPRG_CE,
  output logic                     nWRAM_CE,
  output logic [CNT_W-1:0]         SHIFT_CNT
);

  localparam logic [SHIFT_LEN-1:0] CTRL_RST = SHIFT_LEN'(CTRL_RESET);

  logic [SHIFT_LEN-1:0] ctrl_q, chr0_q, chr1_q, prg_q;
  logic [SHIFT_LEN-1:0] ctrl_d, chr0_d, chr1_d, prg_d;
  logic                 wr;
  logic                 commit;
  reg_idx_e             commit_idx;
  logic [SHIFT_LEN-1:0] commit_data;
  logic                 shift_reset;
  logic [PRG_BANK_BITS-1:0] prg_bank;
  logic [CHR_BANK_BITS-1:0] chr0_bank, chr1_bank;

  assign wr = ~nCPU_ROMSEL & ~nCPU_RW;

  mmc1_serial_loader #(
    .SHIFT_LEN    (SHIFT_LEN),
    .CONSEC_FILTER(CONSEC_FILTER)
  ) u_loader (
    .cpu_m2_i     (CPU_M2),
    .rst_i        (RESET),
    .wr_i         (wr),
    .d0_i         (CPU_D0),
    .d7_i         (CPU_D7),
    .cpu_a_i      (CPU_A),
    .commit_o     (commit),
    .commit_idx_o (commit_idx),
    .commit_data_o(commit_data),
    .shift_reset_o(shift_reset),
    .shift_cnt_o  (SHIFT_CNT)
  );

  // Next register values: a shift reset forces PRG mode 3, a commit writes one register.
  always_comb begin
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    if (shift_reset) begin
      ctrl_d = ctrl_q | CTRL_RST;
    end else if (commit) begin
      case (commit_idx)
        REG_CTRL: ctrl_d = commit_data;
        REG_CHR0: chr0_d = commit_data;
        REG_CHR1: chr1_d = commit_data;
        REG_PRG:  prg_d  = commit_data;
      endcase
    end
  end

  // Register file, updated on the M2 falling edge alongside the loader.
  always_ff @(negedge CPU_M2 or posedge RESET) begin
    if (RESET) begin
      ctrl_q <= CTRL_RST;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end

  // PRG bank decode from the live CPU A14.
  always_comb begin
    prg_bank = prg_q[PRG_BANK_BITS-1:0];
    PRG_A    = prg_bank;
    case (ctrl_q[3:2])
      PRG_MODE_32K_A,
      PRG_MODE_32K_B:     PRG_A = (prg_bank & ~PRG_BANK_BITS'(1)) | PRG_BANK_BITS'(CPU_A[1]);
      PRG_MODE_FIX_FIRST: PRG_A = CPU_A[1] ? prg_bank : '0;
      PRG_MODE_FIX_LAST:  PRG_A = CPU_A[1] ? '1 : prg_bank;
    endcase
  end

  // CHR bank decode from the live PPU A12.
  always_comb begin
    chr0_bank = chr0_q[CHR_BANK_BITS-1:0];
    chr1_bank = chr1_q[CHR_BANK_BITS-1:0];
    if (ctrl_q[4]) begin
      CHR_A = PPU_A[2] ? chr1_bank : chr0_bank;
    end else begin
      CHR_A = (chr0_bank & ~CHR_BANK_BITS'(1)) | CHR_BANK_BITS'(PPU_A[2]);
    end
  end

  // Nametable mirroring select.
  always_comb begin
    CIRAM_A10 = 1'b0;
    case (ctrl_q[1:0])
      MIRROR_ONE_LOW:  CIRAM_A10 = 1'b0;
      MIRROR_ONE_HIGH: CIRAM_A10 = 1'b1;
      MIRROR_VERT:     CIRAM_A10 = PPU_A[0];
      MIRROR_HORZ:     CIRAM_A10 = PPU_A[1];
    endcase
  end

  assign nPRG_CE   = nCPU_ROMSEL | ~nCPU_RW;
  assign nWRAM_CE  = ~(CPU_A_WR & nCPU_ROMSEL & ~(WRAM_DIS_EN & prg_q[SHIFT_LEN-1]));

endmodule
